frame_buf_ptr_mgr: RTL and testbench

Frame-slot pointer manager for the multi-ROI frame buffer, in the `clk_frame_buf` domain between the write-path and read-path controllers. It keeps a ring of up to 2^PTR_WIDTH frame slots, depth set at run time, and hands out write and read slots through request/grant handshakes. It returns each slot's MCB base address and counts committed frames. When full it either rejects the new frame or replaces the newest committed frame, depending on mode.

---
 rtl/frame_buf_pkg.sv | 37 +++
 rtl/frame_buf_ptr_mgr_ring.sv | 57 +++++
 rtl/frame_buf_ptr_mgr.sv | 135 +++++++++++++
 tb/tb_frame_buf_ptr_mgr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types, helpers and MCB section offsets for the frame buffer.
// Callers add the section offsets to a slot base address from frame_buf_ptr_mgr.
package frame_buf_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } r_state_t;

  localparam int unsigned LEADER_START_ADDR  = 0;
  localparam int unsigned TRAILER_START_ADDR = 16;
  localparam int unsigned CHUNK_START_ADDR   = 32;
  localparam int unsigned IMAGE_START_ADDR   = 64;

  // A requested depth of 0 still needs one usable slot.
  function automatic int unsigned clamp_depth(input int unsigned req,
                                              input int unsigned max_slots);
    if (req == 0) return 1;
    if (req > max_slots) return max_slots;
    return req;
  endfunction

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_buf_ptr_mgr_ring.sv
// Slot ring: depth, write/read pointers, committed-frame count.
// Every pointer step wraps at depth_r, which is only loaded on a flush.
module frame_slot_ring #(
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [PTR_WIDTH:0]   flush_depth,
  input  logic                 wr_commit,
  input  logic                 wr_rewind,
  input  logic                 rd_take,
  output logic [PTR_WIDTH:0]   depth_r,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic [PTR_WIDTH-1:0] rd_cur,
  output logic [PTR_WIDTH:0]   cnt
);

  logic [PTR_WIDTH-1:0] rd_ptr;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if ({1'b0, p} >= depth_r - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [PTR_WIDTH-1:0] ptr_dec(input logic [PTR_WIDTH-1:0] p);
    if (p == '0) return PTR_WIDTH'(depth_r - 1'b1);
    return p - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_r <= (PTR_WIDTH+1)'(1 << PTR_WIDTH);
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_cur  <= '0;
      cnt     <= '0;
    end else if (flush) begin
      depth_r <= flush_depth;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_cur  <= '0;
      cnt     <= '0;
    end else begin
      // Rewind and commit are mutually exclusive (idle vs busy writer).
      if (wr_rewind)      wr_ptr <= ptr_dec(wr_ptr);
      else if (wr_commit) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_take) begin
        rd_cur <= rd_ptr;
        rd_ptr <= ptr_inc(rd_ptr);
      end
      cnt <= cnt + (PTR_WIDTH+1)'(wr_commit) - (PTR_WIDTH+1)'(rd_take)
                 - (PTR_WIDTH+1)'(wr_rewind);
    end
  end

endmodule

// File: rtl/frame_buf_ptr_mgr.sv
// Frame-slot pointer manager: write/read FSMs, flush, drop flags around the slot ring.
// Handshakes: start/done are one-cycle pulses; grant/reject answer one cycle later.
module frame_buf_ptr_mgr
  import frame_buf_pkg::*;
#(
  parameter int PTR_WIDTH    = 2,
  parameter int SHORT_REG_WD = 16,
  parameter int ADDR_WD      = 21,
  parameter int SLOT_SHIFT   = ADDR_WD - PTR_WIDTH
) (
  input  logic                    clk_frame_buf,
  input  logic                    reset_frame_buf_n,
  input  logic                    i_stream_enable,
  input  logic                    i_overwrite_en,
  input  logic [SHORT_REG_WD-1:0] iv_frame_depth,
  input  logic                    i_wr_start,
  input  logic                    i_wr_done,
  output logic                    o_wr_grant,
  output logic                    o_wr_reject,
  output logic [PTR_WIDTH-1:0]    ov_wr_ptr,
  output logic [ADDR_WD-1:0]      ov_wr_base,
  input  logic                    i_rd_req,
  input  logic                    i_rd_done,
  output logic                    o_rd_grant,
  output logic [PTR_WIDTH-1:0]    ov_rd_ptr,
  output logic [ADDR_WD-1:0]      ov_rd_base,
  output logic [PTR_WIDTH:0]      ov_frame_cnt,
  output logic                    o_frame_dropped,
  output logic                    o_buf_overflow
);

  localparam int unsigned DEPTH_MAX = 1 << PTR_WIDTH;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [PTR_WIDTH:0]   depth_r, cnt, flush_depth;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_cur;
  logic [PTR_WIDTH+1:0] held;
  logic flush, full, can_overwrite;
  logic rd_take, wr_commit, wr_rewind;
  logic grant_n, reject_n, drop_n;

  assign flush       = !i_stream_enable && (w_state == W_IDLE) && (r_state == R_IDLE);
  assign flush_depth = (PTR_WIDTH+1)'(clamp_depth(32'(iv_frame_depth), DEPTH_MAX));
  assign held        = (PTR_WIDTH+2)'(cnt) + (PTR_WIDTH+2)'(r_state == R_BUSY);
  assign full        = (held == (PTR_WIDTH+2)'(depth_r));
  // A read taken this same cycle leaves one fewer committed frame to replace.
  assign can_overwrite = rd_take ? (cnt >= (PTR_WIDTH+1)'(2)) : (cnt != '0);

  always_comb begin
    r_state_n = r_state;
    rd_take   = 1'b0;
    if (r_state == R_IDLE) begin
      if (i_rd_req && (cnt != '0) && !flush) begin
        rd_take   = 1'b1;
        r_state_n = R_BUSY;
      end
    end else if (i_rd_done) begin
      r_state_n = R_IDLE;
    end
  end

  always_comb begin
    w_state_n = w_state;
    grant_n   = 1'b0;
    reject_n  = 1'b0;
    drop_n    = 1'b0;
    wr_rewind = 1'b0;
    wr_commit = 1'b0;
    if (w_state == W_IDLE) begin
      if (i_wr_start) begin
        if (!i_stream_enable) begin
          reject_n = 1'b1;
        end else if (!full) begin
          grant_n   = 1'b1;
          w_state_n = W_BUSY;
        end else if (i_overwrite_en && can_overwrite) begin
          grant_n   = 1'b1;
          wr_rewind = 1'b1;
          drop_n    = 1'b1;
          w_state_n = W_BUSY;
        end else begin
          reject_n = 1'b1;
          drop_n   = 1'b1;
        end
      end
    end else if (i_wr_done) begin
      wr_commit = 1'b1;
      w_state_n = W_IDLE;
    end
  end

  always_ff @(posedge clk_frame_buf or negedge reset_frame_buf_n) begin
    if (!reset_frame_buf_n) begin
      w_state         <= W_IDLE;
      r_state         <= R_IDLE;
      o_wr_grant      <= 1'b0;
      o_wr_reject     <= 1'b0;
      o_rd_grant      <= 1'b0;
      o_frame_dropped <= 1'b0;
      o_buf_overflow  <= 1'b0;
    end else begin
      w_state         <= w_state_n;
      r_state         <= r_state_n;
      o_wr_grant      <= grant_n;
      o_wr_reject     <= reject_n;
      o_rd_grant      <= rd_take;
      o_frame_dropped <= drop_n;
      if (flush)       o_buf_overflow <= 1'b0;
      else if (drop_n) o_buf_overflow <= 1'b1;
    end
  end

  frame_slot_ring #(.PTR_WIDTH(PTR_WIDTH)) u_ring (
    .clk         (clk_frame_buf),
    .rst_n       (reset_frame_buf_n),
    .flush       (flush),
    .flush_depth (flush_depth),
    .wr_commit   (wr_commit),
    .wr_rewind   (wr_rewind),
    .rd_take     (rd_take),
    .depth_r     (depth_r),
    .wr_ptr      (wr_ptr),
    .rd_cur      (rd_cur),
    .cnt         (cnt)
  );

  assign ov_wr_ptr    = wr_ptr;
  assign ov_rd_ptr    = rd_cur;
  assign ov_wr_base   = {wr_ptr, {SLOT_SHIFT{1'b0}}};
  assign ov_rd_base   = {rd_cur, {SLOT_SHIFT{1'b0}}};
  assign ov_frame_cnt = cnt;

endmodule

// File: tb/tb_frame_buf_ptr_mgr.sv
// Directed bench for frame_buf_ptr_mgr (PTR_WIDTH=2, ADDR_WD=21, slot shift 19).
module tb_frame_buf_ptr_mgr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        se, ow;
  logic [15:0] depth;
  logic        wr_start, wr_done, rd_req, rd_done;
  logic        wr_grant, wr_reject, rd_grant, dropped, overflow;
  logic [1:0]  wr_ptr, rd_ptr;
  logic [20:0] wr_base, rd_base;
  logic [2:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_ptr;

  always #5 clk = ~clk;

  frame_buf_ptr_mgr dut (
    .clk_frame_buf     (clk),
    .reset_frame_buf_n (rst_n),
    .i_stream_enable   (se),
    .i_overwrite_en    (ow),
    .iv_frame_depth    (depth),
    .i_wr_start        (wr_start),
    .i_wr_done         (wr_done),
    .o_wr_grant        (wr_grant),
    .o_wr_reject       (wr_reject),
    .ov_wr_ptr         (wr_ptr),
    .ov_wr_base        (wr_base),
    .i_rd_req          (rd_req),
    .i_rd_done         (rd_done),
    .o_rd_grant        (rd_grant),
    .ov_rd_ptr         (rd_ptr),
    .ov_rd_base        (rd_base),
    .ov_frame_cnt      (frame_cnt),
    .o_frame_dropped   (dropped),
    .o_buf_overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [15:0] d);
    depth = d;
    se = 1'b0;
    tick();
    tick();
    se = 1'b1;
  endtask

  task automatic wr_start_chk(input string tag, input logic exp_grant,
                              input logic [1:0] exp_wptr, input logic exp_drop);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    check({tag, "_grant"}, wr_grant, exp_grant);
    check({tag, "_reject"}, wr_reject, !exp_grant);
    check({tag, "_drop"}, dropped, exp_drop);
    if (exp_grant) begin
      check({tag, "_ptr"}, wr_ptr, exp_wptr);
      check({tag, "_base"}, wr_base, {exp_wptr, 19'd0});
    end
  endtask

  task automatic wr_commit(input string tag, input logic [2:0] exp_cnt);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic rd_frame(input string tag);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    exp_ptr = exp_q.pop_front();
    check({tag, "_rgrant"}, rd_grant, 1'b1);
    check({tag, "_rptr"}, rd_ptr, exp_ptr);
    check({tag, "_rbase"}, rd_base, {exp_ptr, 19'd0});
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check({tag, "_rgrant_pulse"}, rd_grant, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; se = 1'b0; ow = 1'b0; depth = 16'd4;
    wr_start = 1'b0; wr_done = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
    tick();
    tick();
    check("rst_wptr", wr_ptr, 0);
    check("rst_rptr", rd_ptr, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_flags", {wr_grant, wr_reject, rd_grant, dropped, overflow}, 0);
    rst_n = 1'b1;
    flush_to(16'd4);

    // Fill depth 4 without reads, then reject on full.
    for (int i = 0; i < 4; i++) begin
      wr_start_chk("fill", 1'b1, 2'(i), 1'b0);
      wr_commit("fill", 3'(i + 1));
    end
    check("fill_wrap", wr_ptr, 0);
    wr_start_chk("full_rej", 1'b0, 2'd0, 1'b1);
    check("full_rej_ovf", overflow, 1'b1);
    check("full_rej_cnt", frame_cnt, 4);
    tick();
    check("drop_pulse", dropped, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Overwrite replaces the newest committed slot.
    ow = 1'b1;
    wr_start_chk("ovw", 1'b1, 2'd3, 1'b1);
    check("ovw_cnt", frame_cnt, 3);
    wr_commit("ovw", 3'd4);
    check("ovw_wptr", wr_ptr, 0);
    ow = 1'b0;

    flush_to(16'd3);
    check("flush_cnt", frame_cnt, 0);
    check("flush_ovf", overflow, 1'b0);
    check("flush_wptr", wr_ptr, 0);

    // Depth 3 alternating write/read.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(2'(i % 3));
      wr_start_chk("d3", 1'b1, 2'(i % 3), 1'b0);
      wr_commit("d3", 3'd1);
      rd_frame("d3");
      check("d3_cnt_after_rd", frame_cnt, 0);
    end
    check("d3_q_empty", exp_q.size(), 0);

    // Depth 1 with the reader holding the only slot.
    flush_to(16'd1);
    wr_start_chk("d1", 1'b1, 2'd0, 1'b0);
    wr_commit("d1", 3'd1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("d1_rgrant", rd_grant, 1'b1);
    check("d1_cnt", frame_cnt, 0);
    wr_start_chk("d1_rej_ow0", 1'b0, 2'd0, 1'b1);
    ow = 1'b1;
    wr_start_chk("d1_rej_ow1", 1'b0, 2'd0, 1'b1);
    ow = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;

    // Commit and read grant on the same edge.
    flush_to(16'd4);
    wr_start_chk("same", 1'b1, 2'd0, 1'b0);
    wr_commit("same", 3'd1);
    wr_start_chk("same_b", 1'b1, 2'd1, 1'b0);
    wr_done = 1'b1;
    rd_req = 1'b1;
    tick();
    wr_done = 1'b0;
    rd_req = 1'b0;
    check("same_rgrant", rd_grant, 1'b1);
    check("same_cnt", frame_cnt, 1);
    check("same_rptr", rd_ptr, 0);
    check("same_wptr", wr_ptr, 2);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;

    // Depth 0 clamps to 1 slot.
    flush_to(16'd0);
    wr_start_chk("d0", 1'b1, 2'd0, 1'b0);
    wr_commit("d0", 3'd1);
    check("d0_wptr", wr_ptr, 0);
    wr_start_chk("d0_full", 1'b0, 2'd0, 1'b1);

    // Depth 40 clamps to 4; stream disabled mid-write.
    flush_to(16'd40);
    check("d40_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wr_start_chk("d40", 1'b1, 2'(i), 1'b0);
      wr_commit("d40", 3'(i + 1));
    end
    wr_start_chk("d40_last", 1'b1, 2'd3, 1'b0);
    se = 1'b0;
    tick();
    tick();
    check("se_busy_cnt", frame_cnt, 3);
    check("se_busy_wptr", wr_ptr, 3);
    wr_commit("se_done", 3'd4);
    check("se_done_wptr", wr_ptr, 0);
    tick();
    check("se_flush_cnt", frame_cnt, 0);
    check("se_flush_wptr", wr_ptr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
